// File: rtl/alu_shift_sequencer_pkg.sv
// Shared ALU opcode constants, flag bit positions and sequencer state encoding.
package alu_shift_sequencer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W = 5;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_LSL = 5'b01000;
  localparam logic [OP_W-1:0] OP_ASR = 5'b01001;
  localparam logic [OP_W-1:0] OP_LOGIC_FIRST = 5'b10000;
  localparam logic [OP_W-1:0] OP_LOGIC_LAST = 5'b11111;

  localparam int unsigned FLAG_O = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == OP_LSL) || (op == OP_ASR);
  endfunction

  function automatic logic [FLAG_W-1:0] pack_flags(input logic o, input logic s,
                                                   input logic c, input logic z);
    logic [FLAG_W-1:0] f;
    f = '0;
    f[FLAG_O] = o;
    f[FLAG_S] = s;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_shift_sequencer.sv
// Iterates a one-bit-per-pass ALU to perform LSL/ASR by 0..2^AMT_W-1; other ops take one pass.
// Optional ALU_SEQ_ABORT_EN adds i_abort to cancel an operation in flight.
module alu_shift_sequencer
  import alu_shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned AMT_W = SHAMT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [OP_W-1:0]   i_req_op,
  input  logic [WIDTH-1:0]  i_req_a,
  input  logic [WIDTH-1:0]  i_req_b,
  input  logic [AMT_W-1:0]  i_req_amt,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [WIDTH-1:0]  o_rsp_res,
  output logic [FLAG_W-1:0] o_rsp_flags,
`ifdef ALU_SEQ_ABORT_EN
  input  logic              i_abort,
`endif
  output logic [OP_W-1:0]   o_alu_op,
  output logic [WIDTH-1:0]  o_alu_a,
  output logic [WIDTH-1:0]  o_alu_b,
  input  logic [WIDTH-1:0]  i_alu_res,
  input  logic              i_alu_o,
  input  logic              i_alu_s,
  input  logic              i_alu_c,
  input  logic              i_alu_z
);

  state_e             r_state;
  logic [OP_W-1:0]    r_op;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [AMT_W-1:0]   r_count;
  logic [FLAG_W-1:0]  r_flags;
  logic [WIDTH-1:0]   r_rsp_res;
  logic               r_rsp_valid;
  logic               r_req_ready;
  logic               w_abort;

`ifdef ALU_SEQ_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_res   = r_rsp_res;
  assign o_rsp_flags = r_flags;
  assign o_alu_op    = r_op;
  assign o_alu_a     = r_acc;
  assign o_alu_b     = r_b;

  // Sequencer FSM with the pass down-counter; abort outranks everything but reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_acc       <= '0;
      r_b         <= '0;
      r_count     <= '0;
      r_flags     <= '0;
      r_rsp_res   <= '0;
      r_rsp_valid <= 1'b0;
      r_req_ready <= 1'b1;
    end else if (w_abort) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_op        <= i_req_op;
            r_acc       <= i_req_a;
            r_b         <= i_req_b;
            r_req_ready <= 1'b0;
            if (is_shift(i_req_op) && (i_req_amt == '0)) begin
              // Zero-distance shift completes without touching the ALU.
              r_state     <= ST_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_res   <= i_req_a;
              r_flags     <= pack_flags(1'b0, i_req_a[WIDTH-1], 1'b0, i_req_a == '0);
              r_count     <= '0;
            end else begin
              r_state <= ST_RUN;
              r_count <= is_shift(i_req_op) ? i_req_amt : AMT_W'(1);
            end
          end
        end
        ST_RUN: begin
          r_acc   <= i_alu_res;
          r_flags <= pack_flags(i_alu_o, i_alu_s, i_alu_c, i_alu_z);
          r_count <= r_count - AMT_W'(1);
          if (r_count == AMT_W'(1)) begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_res   <= i_alu_res;
          end
        end
        ST_DONE: begin
          if (i_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Scoreboard bench for alu_shift_sequencer with a one-bit-per-pass ALU emulator and a whole-shift reference model.
module tb_alu_shift_sequencer;
  import alu_shift_sequencer_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [AW-1:0] req_amt;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_res;
  logic [3:0]    rsp_flags;
  logic          abort;
  logic [4:0]    alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_res;
  logic          alu_o, alu_s, alu_c, alu_z;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     hold = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    int unsigned  n;
    longint       k;
    logic [4:0]   op;
    logic [W-1:0] b;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_shift_sequencer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_amt   (req_amt),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_res   (rsp_res),
    .o_rsp_flags (rsp_flags),
`ifdef ALU_SEQ_ABORT_EN
    .i_abort     (abort),
`endif
    .o_alu_op    (alu_op),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .i_alu_res   (alu_res),
    .i_alu_o     (alu_o),
    .i_alu_s     (alu_s),
    .i_alu_c     (alu_c),
    .i_alu_z     (alu_z)
  );

  function automatic logic [W-1:0] logic_fn(input logic [2:0] sel, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (sel)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a & ~b;
      3'd3:    return a | ~b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // Single-pass ALU: shifts move exactly one bit; other low opcodes add.
  always_comb begin
    logic [W:0] sum;
    sum = '0;
    alu_res = '0;
    alu_c = 1'b0;
    alu_o = 1'b0;
    if (alu_op == OP_LSL) begin
      alu_res = {alu_a[W-2:0], 1'b0};
      alu_c = alu_a[W-1];
    end else if (alu_op == OP_ASR) begin
      alu_res = {alu_a[W-1], alu_a[W-1:1]};
      alu_c = alu_a[0];
    end else if (alu_op[4]) begin
      alu_res = logic_fn(alu_op[2:0], alu_a, alu_b);
    end else begin
      sum = {1'b0, alu_a} + {1'b0, alu_b};
      alu_res = sum[W-1:0];
      alu_c = sum[W];
      alu_o = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
    end
    alu_s = alu_res[W-1];
    alu_z = (alu_res == '0);
  end

  // Reference: whole shift in one step; carry is the last bit shifted out.
  function automatic void ref_model(input logic [4:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [AW-1:0] amt,
                                    output logic [W-1:0] res, output logic [3:0] fl,
                                    output int unsigned n);
    logic o, c;
    logic [W:0] sum;
    int ai;
    ai = int'(amt);
    o = 1'b0;
    c = 1'b0;
    if (op == OP_LSL || op == OP_ASR) begin
      n = int'(amt);
      if (ai == 0) res = a;
      else if (op == OP_LSL) begin
        res = a << ai;
        c = a[W - ai];
      end else begin
        res = W'($signed(a) >>> ai);
        c = a[ai - 1];
      end
    end else if (op[4]) begin
      n = 1;
      res = logic_fn(op[2:0], a, b);
    end else begin
      n = 1;
      sum = {1'b0, a} + {1'b0, b};
      res = sum[W-1:0];
      c = sum[W];
      o = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
    end
    fl = {o, res[W-1], c, (res == '0)};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] amt, input bit track);
    int g;
    exp_t e;
    longint k;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      fail_now("req_ready_wait");
      return;
    end
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    req_amt = amt;
    k = cyc + 1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 5'($urandom);
    req_a = $urandom;
    req_b = $urandom;
    req_amt = AW'($urandom);
    if (track) begin
      ref_model(op, a, b, amt, e.res, e.flags, e.n);
      e.k = k;
      e.op = op;
      e.b = b;
      q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((q.size() != 0 || !req_ready) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) fail_now("drain");
  endtask

  task automatic wait_rsp_valid();
    int g;
    g = 0;
    while (!rsp_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) fail_now("rsp_valid_wait");
  endtask

  // Consumer back-pressure.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on each new response, checks stability while held and ALU drive during passes.
  initial begin
    exp_t cur;
    bit active;
    active = 1'b0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        active = 1'b0;
        continue;
      end
      if (rsp_valid) begin
        if (!active) begin
          active = 1'b1;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: res=0x%08h with nothing outstanding at cycle %0d",
                     rsp_res, cyc);
            cur.res = rsp_res;
            cur.flags = rsp_flags;
          end else begin
            cur = q.pop_front();
            chk("rsp_res", rsp_res, cur.res);
            chk("rsp_flags", W'(rsp_flags), W'(cur.flags));
            chk("latency", W'(cyc - cur.k), W'(cur.n));
          end
        end else begin
          chk("rsp_res_stable", rsp_res, cur.res);
          chk("rsp_flags_stable", W'(rsp_flags), W'(cur.flags));
        end
        chk("req_ready_in_done", W'(req_ready), W'(0));
        if (rsp_ready) active = 1'b0;
      end else if (!req_ready && q.size() > 0) begin
        chk("alu_op_run", W'(alu_op), W'(q[0].op));
        chk("alu_b_run", alu_b, q[0].b);
      end
    end
  end

  initial begin
    logic [4:0] op;
    logic [AW-1:0] amt;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    req_amt = '0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", W'(req_ready), W'(1));
    chk("reset_rsp_valid", W'(rsp_valid), W'(0));
    chk("reset_rsp_res", rsp_res, W'(0));
    chk("reset_rsp_flags", W'(rsp_flags), W'(0));
    chk("reset_alu_op", W'(alu_op), W'(0));
    chk("reset_alu_a", alu_a, W'(0));
    chk("reset_alu_b", alu_b, W'(0));
    rst_n = 1'b1;

    issue(OP_LSL, 32'h0000_0001, 32'h0, 5'd4, 1'b1);
    issue(OP_LSL, 32'h8000_0001, 32'h0, 5'd1, 1'b1);
    issue(OP_ASR, 32'h8000_0000, 32'h0, 5'd31, 1'b1);
    issue(OP_ASR, 32'h0000_0001, 32'h0, 5'd0, 1'b1);
    issue(OP_LSL, 32'h0000_0000, 32'h0, 5'd0, 1'b1);
    issue(OP_LSL, 32'hFFFF_FFFF, 32'h0, 5'd31, 1'b1);
    wait_idle();

    // XOR with the consumer stalled for five cycles.
    hold = 1'b1;
    issue(5'b10110, 32'h1, 32'h2, 5'd0, 1'b1);
    wait_rsp_valid();
    repeat (5) begin
      @(negedge clk);
      #3;
      chk("hold_rsp_valid", W'(rsp_valid), W'(1));
      chk("hold_rsp_res", rsp_res, 32'h3);
      chk("hold_req_ready", W'(req_ready), W'(0));
    end
    hold = 1'b0;
    wait_idle();

    // Reset during the third pass of a long shift.
    issue(OP_LSL, 32'h1234_5678, 32'h0, 5'd20, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_abort_req_ready", W'(req_ready), W'(1));
    chk("rst_abort_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_abort_rsp_res", rsp_res, W'(0));
    chk("rst_abort_flags", W'(rsp_flags), W'(0));
    chk("rst_abort_alu_op", W'(alu_op), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_abort_idle", W'(req_ready), W'(1));

`ifdef ALU_SEQ_ABORT_EN
    issue(OP_LSL, 32'h1234_5678, 32'h0, 5'd20, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_run_req_ready", W'(req_ready), W'(1));
    chk("abort_run_rsp_valid", W'(rsp_valid), W'(0));
    repeat (40) @(negedge clk);

    hold = 1'b1;
    issue(5'b10110, 32'h5, 32'h6, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_done_rsp_valid", W'(rsp_valid), W'(0));
    hold = 1'b0;

    @(negedge clk);
    req_valid = 1'b1;
    req_op = 5'b10110;
    abort = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    abort = 1'b0;
    chk("abort_idle_req_ready", W'(req_ready), W'(1));
    repeat (10) @(negedge clk);
    chk("abort_idle_no_rsp", W'(rsp_valid), W'(0));
`endif

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0:       op = OP_LSL;
        1:       op = OP_ASR;
        2:       op = OP_LOGIC_FIRST | 5'($urandom_range(0, 15));
        default: op = 5'($urandom_range(0, 7));
      endcase
      amt = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
      issue(op, $urandom, $urandom, amt, 1'b1);
    end
    issue(OP_LOGIC_LAST, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0, 1'b1);

    wait_idle();
    repeat (5) @(negedge clk);
    chk("outstanding", W'(q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_shift_sequencer.md
Name: alu_shift_sequencer

Overview:
Multi-cycle controller in front of the combinational ALU. The ALU shifts (LSL/ASR) by exactly one bit per pass; this block iterates it to perform shifts by 0-31 bits. Non-shift ALU opcodes are issued as a single pass. It sits between the decode/execute control and the ALU, with a valid/ready request and response interface and a registered result and flags.

Parameters:
- WIDTH, 32, datapath width of A, B and result.
- AMT_W, 5, shift-amount width; the maximum shift is 2^AMT_W-1.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request.
- REQ_OP  in  5  ALU opcode.
- REQ_A  in  WIDTH  operand A.
- REQ_B  in  WIDTH  operand B; used by non-shift ops only.
- REQ_AMT  in  AMT_W  shift amount; ignored for non-shift ops.
- RSP_VALID  out  1  result available.
- RSP_READY  in  1  consumer accepts the result.
- RSP_RES  out  WIDTH  final result.
- RSP_FLAGS  out  4  {O,S,C,Z}, captured from the final pass.
- ALU_OP  out  5  opcode to the ALU.
- ALU_A  out  WIDTH  ALU operand A; equals the accumulator.
- ALU_B  out  WIDTH  ALU operand B; equals the latched B.
- ALU_RES  in  WIDTH  ALU result.
- ALU_O, ALU_S, ALU_C, ALU_Z  in  1 each  ALU flags.

Behaviour:
- States: IDLE, RUN, DONE. Reset (RST_N=0 at an edge) forces IDLE.
- Reset values: REQ_READY=1, RSP_VALID=0, RSP_RES=0, RSP_FLAGS=0, accumulator=0, count=0, ALU_OP=0, ALU_B=0.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, latch OP, A→acc, B and AMT.
  - Shift op (LSL or ASR) with AMT>0 → RUN with count=AMT.
  - Shift op with AMT=0 → DONE, RES=A, flags {0, A[WIDTH-1], 0, A==0}.
  - Any other opcode → RUN with count=1.
- RUN:
  - REQ_READY=0. ALU_OP and ALU_B are the latched values; ALU_A=acc.
  - Each cycle: acc←ALU_RES, flags←{ALU_O,ALU_S,ALU_C,ALU_Z}, count←count-1.
  - When count==1 at an edge → DONE.
- DONE:
  - RSP_VALID=1. RSP_RES and RSP_FLAGS are stable.
  - On RSP_READY → IDLE. The next request is accepted only in the following cycle; there is no same-cycle turnaround.
- Latency: request accepted at edge k; RSP_VALID is high from cycle k+N+1, where N=AMT for shifts and N=1 for other ops.
- The carry reported is the carry of the last pass only.
- Undefined opcodes pass through to the ALU as a single pass; no error is raised.
- REQ_* changes while not in IDLE are ignored.
- Reset asserted in RUN or DONE aborts the operation. No response is produced and outputs return to their reset values at that edge.

Optional Feature:
- Macro: ALU_SEQ_ABORT_EN.
- Defined: adds input ABORT (1 bit).
  - ABORT=1 at an edge in RUN or DONE → IDLE, RSP_VALID=0, result discarded.
  - ABORT in IDLE has priority over REQ_VALID: the request is not accepted.
- Undefined: no ABORT port. Operations always complete.

Decomposition:
- Shared package/include holds:
  - the opcode constants (LSL=5'b01000, ASR=5'b01001, and the logical ops 5'b10000-5'b11111) used by the ALU and this block;
  - flag bit indices O=3, S=2, C=1, Z=0;
  - the state encoding.
- No sub-module is needed. The down-counter and FSM live in one module; the ALU is instantiated outside, at the execute level.

Test Plan:
- LSL, A=0x00000001, AMT=4 → ALU_OP=5'b01000 for 4 RUN cycles; RSP_RES=0x00000010, FLAGS C=0 Z=0; RSP_VALID at cycle k+5.
- LSL, A=0x80000001, AMT=1 → RSP_RES=0x00000002, C=1.
- ASR, A=0x80000000, AMT=31 → RSP_RES=0xFFFFFFFF, S=1, Z=0.
- ASR, A=0x00000001, AMT=0 → DONE at k+1 with no ALU pass; RSP_RES=0x00000001, FLAGS=4'b0000.
- XOR (5'b10110), A=1, B=2 → one RUN cycle, RSP_RES=0x00000003. Hold RSP_READY=0 for 5 cycles → RSP_VALID and RSP_RES stay stable and REQ_READY=0.
- LSL, AMT=20, RST_N=0 at the 3rd RUN cycle → next cycle IDLE, REQ_READY=1, RSP_VALID=0, and no response ever appears. Repeat with ABORT under ALU_SEQ_ABORT_EN → same result.
